// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Forward-select encodings and MDU stall FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand forward select for one EX source register.
// MEM result wins over WB result; x0 never forwards.
module fwd_sel_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwriteM,
    input  logic              regwriteW,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        if (regwriteM && (rdM != '0) && (rdM == rs)) begin
            sel = FWD_MEM;
        end else if (regwriteW && (rdW != '0) && (rdW == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage hazard controller: forwarding, load-use, branch flush,
// dmem wait, multi-cycle MDU stall FSM and stall-cycle counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              memreadE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              mdu_startE,
    input  logic              pcsrcE,
    input  logic              dmem_waitM,
    output logic [1:0]        fwdA_E,
    output logic [1:0]        fwdB_E,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              mdu_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam bit LONG = (MDU_LAT > 1);
    localparam logic [CW-1:0] LOAD = CW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);

    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs        (rs1E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .sel       (fwd_a)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs        (rs2E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .sel       (fwd_b)
    );

    assign fwdA_E = fwd_a;
    assign fwdB_E = fwd_b;

    mdu_state_e    state;
    mdu_state_e    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          mdu_stall;
    logic          load_use;

    assign mdu_busy = (state == BUSY);

    assign mdu_stall = ((state == IDLE) && mdu_startE && LONG)
                    || ((state == BUSY) && (cnt != '0));

    assign load_use = memreadE && (rdE != '0)
                   && ((rdE == rs1D) || (rdE == rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Counter runs regardless of dmem_waitM so MDU latency stays fixed.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (mdu_startE && LONG && !pcsrcE) begin
                    state_n = BUSY;
                    cnt_n   = LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (!rst) begin
            if (dmem_waitM) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (mdu_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (pcsrcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stallF && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default instance plus
// MDU_LAT=1 and PERF_W=4 variants driven by the same stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       memreadE, regwriteM, regwriteW;
    logic       mdu_startE, pcsrcE, dmem_waitM;

    logic [1:0]  fwdA_E, fwdB_E;
    logic        stallF, stallD, stallE, stallM;
    logic        flushD, flushE, flushM, flushW;
    logic        mdu_busy;
    logic [15:0] stall_cycles;

    logic [1:0]  l1_fa, l1_fb;
    logic        l1_sF, l1_sD, l1_sE, l1_sM;
    logic        l1_fD, l1_fE, l1_fM, l1_fW;
    logic        l1_busy;
    logic [15:0] l1_sc;

    logic [1:0]  p4_fa, p4_fb;
    logic        p4_sF, p4_sD, p4_sE, p4_sM;
    logic        p4_fD, p4_fE, p4_fM, p4_fW;
    logic        p4_busy;
    logic [3:0]  p4_sc;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit u_dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .memreadE(memreadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .mdu_startE(mdu_startE), .pcsrcE(pcsrcE), .dmem_waitM(dmem_waitM),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    hazard_ctrl_unit #(.MDU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .memreadE(memreadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .mdu_startE(mdu_startE), .pcsrcE(pcsrcE), .dmem_waitM(dmem_waitM),
        .fwdA_E(l1_fa), .fwdB_E(l1_fb),
        .stallF(l1_sF), .stallD(l1_sD), .stallE(l1_sE), .stallM(l1_sM),
        .flushD(l1_fD), .flushE(l1_fE), .flushM(l1_fM), .flushW(l1_fW),
        .mdu_busy(l1_busy), .stall_cycles(l1_sc)
    );

    hazard_ctrl_unit #(.PERF_W(4)) u_p4 (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .memreadE(memreadE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .mdu_startE(mdu_startE), .pcsrcE(pcsrcE), .dmem_waitM(dmem_waitM),
        .fwdA_E(p4_fa), .fwdB_E(p4_fb),
        .stallF(p4_sF), .stallD(p4_sD), .stallE(p4_sE), .stallM(p4_sM),
        .flushD(p4_fD), .flushE(p4_fE), .flushM(p4_fM), .flushW(p4_fW),
        .mdu_busy(p4_busy), .stall_cycles(p4_sc)
    );

    // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
    logic [7:0] ctl;
    assign ctl = {stallF, stallD, stallE, stallM,
                  flushD, flushE, flushM, flushW};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_in();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        rdE = 0; rdM = 0; rdW = 0;
        memreadE = 0; regwriteM = 0; regwriteW = 0;
        mdu_startE = 0; pcsrcE = 0; dmem_waitM = 0;
    endtask

    logic [7:0] mdu_ctl [5];
    logic       mdu_bsy [5];

    initial begin
        mdu_ctl = '{8'hE2, 8'hE2, 8'hE2, 8'h00, 8'h00};
        mdu_bsy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        clear_in();
        rst = 1'b1;
        step();
        step();
        dmem_waitM = 1'b1;
        settle();
        check("rst_ctl", 32'(ctl), 32'h00);
        check("rst_busy", 32'(mdu_busy), 32'h0);
        check("rst_sc", 32'(stall_cycles), 32'h0);

        step();
        clear_in();
        rst = 1'b0;

        // Forwarding
        rs1E = 3; rs2E = 4; rdM = 3; rdW = 3;
        regwriteM = 1; regwriteW = 1;
        settle();
        check("fwdA_mem", 32'(fwdA_E), 32'h2);
        check("fwdB_none", 32'(fwdB_E), 32'h0);
        regwriteM = 0;
        settle();
        check("fwdA_wb", 32'(fwdA_E), 32'h1);
        rs2E = 3; rdM = 3; regwriteM = 1;
        settle();
        check("fwdB_mem", 32'(fwdB_E), 32'h2);
        rdM = 0; rdW = 0;
        settle();
        check("fwdA_rf", 32'(fwdA_E), 32'h0);
        rs1E = 0;
        settle();
        check("fwdA_x0", 32'(fwdA_E), 32'h0);

        // Load-use
        step();
        clear_in();
        memreadE = 1; rdE = 3; rs1D = 3;
        settle();
        check("lu_hit", 32'(ctl), 32'hC4);
        step();
        clear_in();
        settle();
        check("lu_clear", 32'(ctl), 32'h00);
        check("sc_lu", 32'(stall_cycles), 32'd1);
        memreadE = 1; rdE = 9; rs1D = 7; rs2D = 8;
        settle();
        check("lu_miss", 32'(ctl), 32'h00);
        rdE = 0; rs1D = 0;
        settle();
        check("lu_x0", 32'(ctl), 32'h00);

        // MDU, latency 4: three stall cycles, three busy cycles
        step();
        clear_in();
        mdu_startE = 1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) mdu_startE = 0;
            settle();
            check($sformatf("mdu_ctl%0d", i), 32'(ctl), 32'(mdu_ctl[i]));
            check($sformatf("mdu_bsy%0d", i), 32'(mdu_busy),
                  32'(mdu_bsy[i]));
            if (i == 0) begin
                check("lat1_stall", 32'(l1_sF), 32'h0);
            end
            step();
        end
        check("lat1_busy", 32'(l1_busy), 32'h0);
        check("sc_mdu", 32'(stall_cycles), 32'd4);

        // dmem beats branch and load-use
        dmem_waitM = 1; pcsrcE = 1;
        memreadE = 1; rdE = 3; rs1D = 3;
        settle();
        check("prio_dmem", 32'(ctl), 32'hF1);
        step();
        dmem_waitM = 0;
        settle();
        check("prio_br", 32'(ctl), 32'h0C);
        check("sc_dmem", 32'(stall_cycles), 32'd5);

        // dmem during final BUSY cycle; FSM still leaves BUSY
        step();
        clear_in();
        mdu_startE = 1;
        settle();
        check("ov_start", 32'(ctl), 32'hE2);
        step();
        mdu_startE = 0;
        step();
        step();
        dmem_waitM = 1;
        settle();
        check("ov_busy", 32'(mdu_busy), 32'h1);
        check("ov_ctl", 32'(ctl), 32'hF1);
        step();
        dmem_waitM = 0;
        settle();
        check("ov_idle", 32'(mdu_busy), 32'h0);
        check("ov_clear", 32'(ctl), 32'h00);
        check("sc_ov", 32'(stall_cycles), 32'd9);

        // Reset in the second BUSY cycle
        mdu_startE = 1;
        step();
        mdu_startE = 0;
        step();
        rst = 1;
        settle();
        check("rb_ctl", 32'(ctl), 32'h00);
        step();
        rst = 0;
        settle();
        check("rb_busy", 32'(mdu_busy), 32'h0);
        check("rb_sc", 32'(stall_cycles), 32'h0);
        check("rb_ctl2", 32'(ctl), 32'h00);

        // Saturation of the 4-bit counter
        dmem_waitM = 1;
        repeat (20) step();
        dmem_waitM = 0;
        settle();
        check("sat_p4", 32'(p4_sc), 32'd15);
        check("sat_main", 32'(stall_cycles), 32'd20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the 5-stage RISC-V load-use hazard unit. Adds EX-stage forwarding selects, branch-taken flushes and data-memory wait stalls. Adds a multi-cycle MDU (mul/div) stall FSM with a latency counter, plus a saturating stall-cycle performance counter. Sits beside the pipeline datapath and drives all stage enables and flushes.

Parameters:
REG_AW, 5, register address width
MDU_LAT, 4, total EX occupancy in cycles of a multi-cycle MDU op (>=1; 1 means no stall)
PERF_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
rs1D, rs2D  in  REG_AW  source regs of instruction in Decode
rs1E, rs2E  in  REG_AW  source regs of instruction in Execute
rdE, rdM, rdW  in  REG_AW  destination regs in EX/MEM/WB
memreadE  in  1  load in Execute
regwriteM, regwriteW  in  1  writeback enables in MEM/WB
mdu_startE  in  1  multi-cycle MDU op present in Execute
pcsrcE  in  1  branch/jump taken, resolved in Execute
dmem_waitM  in  1  data memory not ready for access in MEM
fwdA_E, fwdB_E  out  2  operand forward select: 00 regfile, 01 WB result, 10 MEM ALU result
stallF, stallD, stallE, stallM  out  1  hold stage register
flushD, flushE, flushM, flushW  out  1  insert bubble into stage register
mdu_busy  out  1  FSM in BUSY
stall_cycles  out  PERF_W  count of cycles with stallF=1

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous, active-high.
- Register match rule: register 0 never matches (rd==0 means no hazard or forward).
- Forwarding (combinational): fwdA_E=10 if regwriteM && rdM==rs1E. Else 01 if regwriteW && rdW==rs1E. Else 00. MEM takes priority over WB. fwdB_E uses rs2E with the same rule.
- FSM states: IDLE and BUSY. The remaining-cycle counter is ceil(log2(MDU_LAT)) bits wide (min 1).
- IDLE -> BUSY: taken when mdu_startE && MDU_LAT>1 && !pcsrc-flush. The counter loads MDU_LAT-2.
- BUSY: the counter decrements every cycle, independent of dmem_waitM. On counter==0, the next state is IDLE, so the op occupies EX for exactly MDU_LAT cycles.
- mdu_stall: (state==IDLE && mdu_startE && MDU_LAT>1) || (state==BUSY && counter!=0).
- Stall priority 1, dmem_waitM: stallF=stallD=stallE=stallM=1, flushW=1. All other stalls and flushes are suppressed. pcsrcE is ignored because EX is frozen.
- Stall priority 2, mdu_stall: stallF=stallD=stallE=1, flushM=1. pcsrcE and load-use are ignored.
- Stall priority 3, pcsrcE: flushD=1, flushE=1. Any load-use stall this cycle is suppressed, since the dependent instruction is squashed.
- Stall priority 4, load-use: memreadE && rdE!=0 && (rdE==rs1D || rdE==rs2D). Drives stallF=stallD=1 and flushE=1.
- Default: with no stall or flush condition, all stall and flush outputs are 0.
- stall_cycles: increments on every cycle with stallF=1 and saturates at 2^PERF_W-1 with no wrap.
- Reset values: state=IDLE, counter=0, stall_cycles=0. All stall/flush outputs are forced 0 while rst=1. fwd selects stay combinational.
- Reset mid-BUSY: the FSM returns to IDLE on that edge. mdu_busy=0 the next cycle.
- Simultaneous dmem_waitM and BUSY expiry: the FSM still leaves BUSY and stallE is driven by dmem_waitM alone.

Decomposition:
- Shared package hazard_pkg holds:
  - the fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the mdu_state_e enum: IDLE, BUSY.
- Sub-module fwd_sel_unit: one instance per operand, pure combinational. Instantiated twice.
- FSM, priority logic and perf counter stay in the top module.

Test Plan:
- Forwarding: rs1E=3, rdM=3, regwriteM=1, rdW=3, regwriteW=1 -> fwdA_E=10. Drop regwriteM -> 01. Set rdM=rdW=0 -> 00.
- Load-use: memreadE=1, rdE=3, rs1D=3 -> stallF=stallD=flushE=1 for one cycle. Repeat with rdE=9, rs1D=7, rs2D=8 -> all 0. Repeat with rdE=0 -> all 0.
- MDU, MDU_LAT=4: pulse mdu_startE -> stallF/stallD/stallE/flushM high for exactly 3 cycles, mdu_busy high for 3 cycles, then all released. Repeat with MDU_LAT=1 -> no stall.
- Priority, dmem over MDU and branch: dmem_waitM=1 with pcsrcE=1 and load-use present -> all four stalls=1, flushW=1, flushD=flushE=0.
- Priority, branch over load-use: pcsrcE=1 with load-use -> flushD=flushE=1, stallF=0.
- Reset and counter: assert rst in the 2nd BUSY cycle -> next cycle mdu_busy=0, stall_cycles=0. With PERF_W=4, hold dmem_waitM for 20 cycles -> stall_cycles=15.
